sram_stream_reader: RTL
=======================

# sram_stream_reader

Test-runner-side Avalon-MM read master sitting directly upstream of the SRAM arbiter's test-runner slave port (`tr_*`). On `start` it reads `word_count` consecutive words from `base_addr`, tolerating `waitrequest` stalls and arbitrary read latency. It buffers returned words in an internal FIFO and presents them to the test-vector consumer as a valid/ready stream. Outstanding reads are credit-limited so no returned word is ever dropped.

## Interface
- `ADDR_WIDTH`, 20, word address width
- `DATA_WIDTH`, 16, data word width
- `BE_WIDTH`, DATA_WIDTH/8, byte-enable width
- `FIFO_DEPTH`, 8, buffer depth in words; power of two, at least 2
- `clock`  in  1  sole clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a transfer; ignored unless IDLE
- `abort`  in  1  cancel the current transfer; ignored in IDLE
- `base_addr`  in  ADDR_WIDTH  first word address, sampled on accepted `start`
- `word_count`  in  ADDR_WIDTH+1  words to read, sampled on accepted `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last word is popped
- `tr_address`  out  ADDR_WIDTH  read address
- `tr_byteenable`  out  BE_WIDTH  always all-ones
- `tr_read`  out  1  read request
- `tr_readdata`  in  DATA_WIDTH  returned word
- `tr_readdataready`  in  1  `tr_readdata` is valid this cycle
- `tr_waitrequest`  in  1  slave stall; request is not accepted while high
- `out_data`  out  DATA_WIDTH  head-of-FIFO word
- `out_valid`  out  1  FIFO not empty
- `out_ready`  in  1  consumer accepts `out_data` when high with `out_valid`

## Operation
- States:
  - IDLE: no transfer.
  - ISSUE: issuing reads.
  - DRAIN: all reads issued, waiting for the FIFO to empty.
  - FLUSH: aborting, discarding outstanding responses.
- Reset values: state IDLE; `tr_read`, `busy`, `done`, `out_valid` all 0; `tr_address` 0; FIFO empty; all counters 0.
- IDLE + `start`, `word_count`≠0: latch the address and remaining count, then go to ISSUE.
- IDLE + `start`, `word_count`=0: stay IDLE, pulse `done` the next cycle, issue no reads.
- A read is accepted in any cycle where `tr_read`=1 and `tr_waitrequest`=0. On acceptance:
  - address increments by 1, wrapping modulo 2^ADDR_WIDTH;
  - remaining count decrements;
  - outstanding count increments.
- While `tr_waitrequest`=1, `tr_address` and `tr_read` hold stable.
- Credit rule: `tr_read` is asserted only when outstanding + FIFO occupancy < FIFO_DEPTH and remaining > 0.
- ISSUE → DRAIN in the cycle the last read is accepted.
- Responses: each `tr_readdataready`=1 pushes `tr_readdata` into the FIFO and decrements outstanding. Responses arrive in order, one per cycle at most.
- DRAIN → IDLE when outstanding=0 and the FIFO becomes empty, i.e. the final pop. `done` pulses in the cycle after that final pop.
- Pop: in any cycle with `out_valid`=1 and `out_ready`=1. A simultaneous push and pop is legal, including when the FIFO is full, and occupancy is unchanged.
- `abort` in ISSUE or DRAIN:
  - `tr_read` deasserts next cycle, unless a request is currently stalled, in which case it holds until accepted;
  - FIFO is cleared and `out_valid` drops next cycle;
  - state goes to FLUSH.
- FLUSH: responses are discarded. FLUSH → IDLE when outstanding=0. No `done` pulse.
- `reset` mid-transfer returns to reset values next edge. Responses still in flight from the slave are not this block's concern; the arbiter is reset with it.
- `start` while busy is ignored. `abort` in FLUSH is ignored.

## Timing
- `start` accepted at edge N → `tr_read`=1 from N+1, with `tr_address`=`base_addr`.
- Zero-stall, full credit: one read accepted per cycle.
- Push at edge N → `out_valid`=1 from N+1. Write-to-read bypass in the same cycle is not allowed.
- `out_data` is combinational from the FIFO head register and stable while `out_valid`=1 and `out_ready`=0.
- Throughput is 1 word/cycle sustained when slave round-trip latency ≤ FIFO_DEPTH−1 cycles.

## Test plan
- Basic transfer:
  - stimulus: `base_addr`=0x00010, `word_count`=4, `out_ready`=1, slave latency 2, SRAM holds data=address;
  - required: `out_data` sequence 0x10, 0x11, 0x12, 0x13; one `done` pulse; `busy` low afterwards.
- Wrap:
  - stimulus: `base_addr`=0xFFFFE, `word_count`=4;
  - required: addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Backpressure:
  - stimulus: `word_count`=20, `out_ready`=0 for 30 cycles, then 1;
  - required: outstanding + occupancy never exceeds 8; no lost or duplicated words; all 20 delivered in order.
- Stall:
  - stimulus: `tr_waitrequest` high 3 cycles on the second read;
  - required: `tr_address` held at `base_addr`+1 throughout; exactly `word_count` accepted reads.
- Abort with reads in flight:
  - stimulus: `word_count`=16, `abort` after 5 accepted reads with 2 responses pending;
  - required: 2 responses discarded; `out_valid`=0; return to IDLE with no `done`; a new `start` then succeeds.
- Zero count and reset:
  - stimulus: `word_count`=0; then `reset` mid-transfer;
  - required: zero count gives `done` one cycle after `start` with no `tr_read`; reset forces all outputs to reset values.

Source files
------------

// File: rtl/sram_stream_reader_if.sv
// Bundles the Avalon-MM read-master signals toward the SRAM arbiter and the
// valid/ready output stream toward the test-vector consumer.
interface sram_stream_reader_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] tr_address;
    logic [BE_WIDTH-1:0]   tr_byteenable;
    logic                  tr_read;
    logic [DATA_WIDTH-1:0] tr_readdata;
    logic                  tr_readdataready;
    logic                  tr_waitrequest;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output tr_address, tr_byteenable, tr_read, out_data, out_valid,
        input  tr_readdata, tr_readdataready, tr_waitrequest, out_ready
    );

    modport slave (
        input  tr_address, tr_byteenable, tr_read, out_data, out_valid,
        output tr_readdata, tr_readdataready, tr_waitrequest, out_ready
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Credit-limited Avalon-MM burst reader: fetches word_count words from base_addr
// into a small FIFO and streams them out over valid/ready.
module sram_stream_reader #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    sram_stream_reader_if.master  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         count;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  hold;
    logic                  done_q;

    logic read, accept, rsp, push, pop, credit_ok;
    logic take_start, zero_start, take_abort, last_pop;

    // Every returned word must have a FIFO slot reserved before its read issues.
    assign credit_ok  = ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH);
    assign accept     = read && !bus.tr_waitrequest;
    assign take_start = (state == IDLE) && start;
    assign zero_start = take_start && (word_count == '0);
    assign take_abort = abort && ((state == ISSUE) || (state == DRAIN));
    assign rsp        = bus.tr_readdataready && (state != IDLE);
    assign push       = rsp && ((state == ISSUE) || (state == DRAIN)) && !take_abort;
    assign pop        = (count != '0) && bus.out_ready;
    assign last_pop   = (state == DRAIN) && (outstanding == '0) && (count == CW'(1)) && pop;

    always_comb begin
        read      = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take_start && !zero_start) state_nxt = ISSUE;
            end
            ISSUE: begin
                read = (remaining != '0) && credit_ok;
                if (take_abort) state_nxt = FLUSH;
                else if (accept && (remaining == (ADDR_WIDTH+1)'(1))) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (take_abort) state_nxt = FLUSH;
                else if (last_pop) state_nxt = IDLE;
            end
            FLUSH: begin
                // A request stalled at abort time must still complete the handshake.
                read = hold;
                if ((outstanding == '0) && !hold) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            outstanding <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            hold        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            done_q      <= zero_start || last_pop;
            outstanding <= outstanding + CW'(accept) - CW'(rsp);

            if (take_start) begin
                addr      <= base_addr;
                remaining <= word_count;
            end else if (accept) begin
                addr      <= addr + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH+1)'(1);
            end

            if (take_abort) hold <= read && bus.tr_waitrequest;
            else if (accept) hold <= 1'b0;

            if (take_abort) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.tr_readdata;
    end

    assign bus.tr_address    = addr;
    assign bus.tr_byteenable = {BE_WIDTH{1'b1}};
    assign bus.tr_read       = read;
    assign bus.out_data      = mem[rd_ptr];
    assign bus.out_valid     = (count != '0);
    assign busy              = (state != IDLE);
    assign done              = done_q;
endmodule
